// File: rtl/RV32I_defines.sv
// RV32I instruction mnemonics shared by the front end.
package RV32I_defines_pkg;

  typedef enum logic [4:0] {
    LUI, AUIPC, JAL, JALR, BEQ, BNE,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW, ADDI, ADD
  } RV32I_INSTRUCTION_MNEMONIC_t;

endpackage

// File: rtl/fe_pkg.sv
// Front-end shared types: load-unit FSM states and load decode helper.
package fe_pkg;
  import RV32I_defines_pkg::*;

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} lau_state_e;

  typedef struct packed {
    logic       legal;
    logic [2:0] size_bytes;
    logic       sign_ext;
  } load_info_t;

  // LW is marked signed so a 64-bit datapath sign-extends the word.
  function automatic load_info_t decode_load(input RV32I_INSTRUCTION_MNEMONIC_t m);
    load_info_t info;
    info = '0;
    case (m)
      LB:      info = '{legal: 1'b1, size_bytes: 3'd1, sign_ext: 1'b1};
      LH:      info = '{legal: 1'b1, size_bytes: 3'd2, sign_ext: 1'b1};
      LW:      info = '{legal: 1'b1, size_bytes: 3'd4, sign_ext: 1'b1};
      LBU:     info = '{legal: 1'b1, size_bytes: 3'd1, sign_ext: 1'b0};
      LHU:     info = '{legal: 1'b1, size_bytes: 3'd2, sign_ext: 1'b0};
      default: info = '0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed bytes from a two-beat window and sign/zero-extends them.
module load_extend #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] beat0_i,
  input  logic [DATA_W-1:0] beat1_i,
  input  logic [OFF_W-1:0]  offset_i,
  input  logic [2:0]        size_i,
  input  logic              sign_i,
  output logic [DATA_W-1:0] data_o
);

  logic [31:0] raw;

  // beat1 sits above beat0 so a word-crossing field is contiguous after the shift.
  assign raw = 32'({beat1_i, beat0_i} >> {offset_i, 3'b000});

  always_comb begin
    data_o = '0;
    case (size_i)
      3'd1: begin
        if (sign_i) data_o = DATA_W'($signed(raw[7:0]));
        else        data_o = DATA_W'(raw[7:0]);
      end
      3'd2: begin
        if (sign_i) data_o = DATA_W'($signed(raw[15:0]));
        else        data_o = DATA_W'(raw[15:0]);
      end
      default: begin
        if (sign_i) data_o = DATA_W'($signed(raw));
        else        data_o = DATA_W'(raw);
      end
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// Load alignment unit: issues one or two word reads per load and returns
// the selected, extended field as a single-cycle writeback.
module load_align_unit
  import RV32I_defines_pkg::*;
  import fe_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 32,
  parameter bit MISALIGNED_EN = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [ADDR_W-1:0]           load_addr,
  input  RV32I_INSTRUCTION_MNEMONIC_t load_mnemonic,
  input  logic [4:0]                  load_rd,
  output logic                        bus_req,
  output logic [ADDR_W-1:0]           bus_addr,
  input  logic                        bus_gnt,
  input  logic                        bus_rvalid,
  input  logic [DATA_W-1:0]           bus_rddata,
  output logic                        wb_valid,
  output logic [4:0]                  wb_rd,
  output logic [DATA_W-1:0]           wb_data,
  output logic                        load_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_width
    $error("load_align_unit: DATA_W must be 32 or 64");
  end

  lau_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]        rd_q, rd_d;
  logic [2:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [DATA_W-1:0] beat0_q, beat0_d;
  logic [DATA_W-1:0] beat1_q, beat1_d;
  logic              err_q, err_d;

  load_info_t        in_info;
  logic              in_cross;
  logic              q_cross;
  logic [ADDR_W-1:0] word_addr;
  logic [DATA_W-1:0] ext_data;

  function automatic logic crosses(input logic [OFF_W-1:0] off, input logic [2:0] nbytes);
    return (4'(off) + 4'(nbytes)) > 4'(BYTES);
  endfunction

  assign in_info   = decode_load(load_mnemonic);
  assign in_cross  = crosses(load_addr[OFF_W-1:0], in_info.size_bytes);
  assign q_cross   = crosses(addr_q[OFF_W-1:0], size_q);
  assign word_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign load_err  = err_q;

  load_extend #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_extend (
    .beat0_i  (beat0_q),
    .beat1_i  (beat1_q),
    .offset_i (addr_q[OFF_W-1:0]),
    .size_i   (size_q),
    .sign_i   (sign_q),
    .data_o   (ext_data)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    size_d     = size_q;
    sign_d     = sign_q;
    beat0_d    = beat0_q;
    beat1_d    = beat1_q;
    err_d      = 1'b0;
    load_ready = 1'b0;
    bus_req    = 1'b0;
    bus_addr   = '0;
    wb_valid   = 1'b0;
    wb_rd      = '0;
    wb_data    = '0;

    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          if (!in_info.legal || (in_cross && !MISALIGNED_EN)) begin
            err_d = 1'b1;
          end else begin
            addr_d  = load_addr;
            rd_d    = load_rd;
            size_d  = in_info.size_bytes;
            sign_d  = in_info.sign_ext;
            state_d = REQ0;
          end
        end
      end
      REQ0: begin
        bus_req  = 1'b1;
        bus_addr = word_addr;
        if (bus_gnt) state_d = WAIT0;
      end
      WAIT0: begin
        if (bus_rvalid) begin
          beat0_d = bus_rddata;
          state_d = q_cross ? REQ1 : DONE;
        end
      end
      REQ1: begin
        bus_req  = 1'b1;
        bus_addr = word_addr + ADDR_W'(BYTES);
        if (bus_gnt) state_d = WAIT1;
      end
      WAIT1: begin
        if (bus_rvalid) begin
          beat1_d = bus_rddata;
          state_d = DONE;
        end
      end
      DONE: begin
        wb_valid = 1'b1;
        wb_rd    = rd_q;
        wb_data  = ext_data;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rd_q    <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      beat0_q <= '0;
      beat1_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      beat0_q <= beat0_d;
      beat1_q <= beat1_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: aligned, split, wrap, stall, reject and reset cases.
module tb_load_align_unit;
  import RV32I_defines_pkg::*;

  logic                        clk;
  logic                        rst;
  logic                        load_valid;
  logic [31:0]                 load_addr;
  RV32I_INSTRUCTION_MNEMONIC_t load_mnemonic;
  logic [4:0]                  load_rd;
  logic                        bus_gnt;
  logic                        bus_rvalid;
  logic [31:0]                 bus_rddata;

  logic        load_ready, bus_req, wb_valid, load_err;
  logic [31:0] bus_addr, wb_data;
  logic [4:0]  wb_rd;

  logic        na_load_ready, na_bus_req, na_wb_valid, na_load_err;
  logic [31:0] na_bus_addr, na_wb_data;
  logic [4:0]  na_wb_rd;

  int n_tests;
  int n_fail;

  load_align_unit dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_mnemonic(load_mnemonic), .load_rd(load_rd),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rddata(bus_rddata), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .load_err(load_err)
  );

  load_align_unit #(.MISALIGNED_EN(1'b0)) dut_na (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(na_load_ready),
    .load_addr(load_addr), .load_mnemonic(load_mnemonic), .load_rd(load_rd),
    .bus_req(na_bus_req), .bus_addr(na_bus_addr), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rddata(bus_rddata), .wb_valid(na_wb_valid),
    .wb_rd(na_wb_rd), .wb_data(na_wb_data), .load_err(na_load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one load, grants every request at once and returns read data the
  // following cycle; reports what the writeback looked like and when it came.
  task automatic run_load(input logic [31:0] addr, input RV32I_INSTRUCTION_MNEMONIC_t mn,
                          input logic [4:0] rd, input logic [31:0] d0, input logic [31:0] d1,
                          output int lat, output logic [31:0] data, output logic [4:0] wrd,
                          output int nreq, output logic [31:0] a0, output logic [31:0] a1);
    logic pend;
    load_valid = 1'b1; load_addr = addr; load_mnemonic = mn; load_rd = rd;
    tick();
    load_valid = 1'b0;
    lat = -1; data = '0; wrd = '0; nreq = 0; a0 = '0; a1 = '0; pend = 1'b0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      if (pend) begin
        bus_rvalid = 1'b1;
        bus_rddata = (nreq == 1) ? d0 : d1;
        pend = 1'b0;
      end
      if (wb_valid) begin
        lat = c; data = wb_data; wrd = wb_rd;
      end else if (bus_req) begin
        if (nreq == 0) a0 = bus_addr; else a1 = bus_addr;
        nreq++;
        bus_gnt = 1'b1;
        pend = 1'b1;
      end
      tick();
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_tests++;
    if ({load_ready, bus_req, wb_valid, load_err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 1000", {load_ready, bus_req, wb_valid, load_err});
    end
    n_tests++;
    if ({bus_addr, wb_rd, wb_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got addr %h rd %h data %h expected all zero", bus_addr, wb_rd, wb_data);
    end
  endtask

  task automatic test_aligned();
    logic [31:0] a_t [5] = '{32'h1003, 32'h1002, 32'h1000, 32'h1001, 32'h1004};
    RV32I_INSTRUCTION_MNEMONIC_t m_t [5] = '{LB, LHU, LH, LBU, LW};
    logic [31:0] d_t [5] = '{32'h80000000, 32'hBEEF1234, 32'h00008001, 32'h0000F000, 32'hCAFEBABE};
    logic [31:0] e_t [5] = '{32'hFFFFFF80, 32'h0000BEEF, 32'hFFFF8001, 32'h000000F0, 32'hCAFEBABE};
    logic [31:0] w_t [5] = '{32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1004};
    int lat, nreq;
    logic [31:0] data, a0, a1;
    logic [4:0] wrd;
    for (int i = 0; i < 5; i++) begin
      run_load(a_t[i], m_t[i], 5'(i + 1), d_t[i], 32'h0, lat, data, wrd, nreq, a0, a1);
      n_tests++;
      if (data !== e_t[i]) begin
        n_fail++; $display("FAIL aligned%0d_data: got %h expected %h", i, data, e_t[i]);
      end
      n_tests++;
      if (lat !== 3 || nreq !== 1) begin
        n_fail++; $display("FAIL aligned%0d_timing: got lat %0d reqs %0d expected lat 3 reqs 1", i, lat, nreq);
      end
      n_tests++;
      if (a0 !== w_t[i]) begin
        n_fail++; $display("FAIL aligned%0d_addr: got %h expected %h", i, a0, w_t[i]);
      end
      n_tests++;
      if (wrd !== 5'(i + 1)) begin
        n_fail++; $display("FAIL aligned%0d_rd: got %0d expected %0d", i, wrd, i + 1);
      end
    end
    n_tests++;
    if ({wb_valid, wb_rd, wb_data} !== '0 || load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wb_idle_zero: got valid %b rd %h data %h ready %b expected 0 0 0 1", wb_valid, wb_rd, wb_data, load_ready);
    end
  endtask

  task automatic test_split();
    logic [31:0] a_t [3] = '{32'h1002, 32'h1003, 32'hFFFFFFFE};
    RV32I_INSTRUCTION_MNEMONIC_t m_t [3] = '{LW, LH, LW};
    logic [31:0] d0_t [3] = '{32'h33445566, 32'h11223344, 32'h12345678};
    logic [31:0] d1_t [3] = '{32'h778899AA, 32'hAABBCCFF, 32'h9ABCDEF0};
    logic [31:0] e_t [3] = '{32'h99AA3344, 32'hFFFFFF11, 32'hDEF01234};
    logic [31:0] w0_t [3] = '{32'h1000, 32'h1000, 32'hFFFFFFFC};
    logic [31:0] w1_t [3] = '{32'h1004, 32'h1004, 32'h00000000};
    int lat, nreq;
    logic [31:0] data, a0, a1;
    logic [4:0] wrd;
    for (int i = 0; i < 3; i++) begin
      run_load(a_t[i], m_t[i], 5'(20 + i), d0_t[i], d1_t[i], lat, data, wrd, nreq, a0, a1);
      n_tests++;
      if (data !== e_t[i] || wrd !== 5'(20 + i)) begin
        n_fail++; $display("FAIL split%0d_data: got %h rd %0d expected %h rd %0d", i, data, wrd, e_t[i], 20 + i);
      end
      n_tests++;
      if (lat !== 5 || nreq !== 2) begin
        n_fail++; $display("FAIL split%0d_timing: got lat %0d reqs %0d expected lat 5 reqs 2", i, lat, nreq);
      end
      n_tests++;
      if (a0 !== w0_t[i] || a1 !== w1_t[i]) begin
        n_fail++; $display("FAIL split%0d_addr: got %h/%h expected %h/%h", i, a0, a1, w0_t[i], w1_t[i]);
      end
    end
  endtask

  task automatic test_illegal();
    load_valid = 1'b1; load_addr = 32'h1000; load_mnemonic = SW; load_rd = 5'd7;
    tick();
    load_valid = 1'b0;
    n_tests++;
    if ({load_err, bus_req, load_ready} !== 3'b101) begin
      n_fail++; $display("FAIL illegal_pulse: got err/req/ready %b expected 101", {load_err, bus_req, load_ready});
    end
    tick();
    n_tests++;
    if ({load_err, bus_req, wb_valid, load_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL illegal_after: got err/req/wb/ready %b expected 0001", {load_err, bus_req, wb_valid, load_ready});
    end
  endtask

  task automatic test_gnt_stall();
    load_valid = 1'b1; load_addr = 32'h1006; load_mnemonic = LHU; load_rd = 5'd9;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rddata = 32'hDEADBEEF;
      n_tests++;
      if (bus_req !== 1'b1 || bus_addr !== 32'h1004) begin
        n_fail++; $display("FAIL stall%0d_req: got req %b addr %h expected 1 00001004", i, bus_req, bus_addr);
      end
      tick();
    end
    bus_rvalid = 1'b0; bus_gnt = 1'b1;
    n_tests++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h1004) begin
      n_fail++; $display("FAIL stall_grant_req: got req %b addr %h expected 1 00001004", bus_req, bus_addr);
    end
    tick();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rddata = 32'h7FFF0000;
    n_tests++;
    if (wb_valid !== 1'b0 || bus_req !== 1'b0) begin
      n_fail++; $display("FAIL stall_wait: got wb %b req %b expected 0 0", wb_valid, bus_req);
    end
    tick();
    bus_rvalid = 1'b0;
    n_tests++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h00007FFF || wb_rd !== 5'd9) begin
      n_fail++; $display("FAIL stall_wb: got valid %b data %h rd %0d expected 1 00007fff 9", wb_valid, wb_data, wb_rd);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat, nreq;
    logic [31:0] data, a0, a1;
    logic [4:0] wrd;
    load_valid = 1'b1; load_addr = 32'h3000; load_mnemonic = LW; load_rd = 5'd4;
    tick();
    load_valid = 1'b0; bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (load_ready !== 1'b1 || bus_req !== 1'b0) begin
      n_fail++; $display("FAIL midreset_idle: got ready %b req %b expected 1 0", load_ready, bus_req);
    end
    for (int i = 0; i < 2; i++) begin
      bus_rvalid = 1'b1; bus_rddata = 32'hFFFFFFFF;
      tick();
      n_tests++;
      if (wb_valid !== 1'b0 || load_ready !== 1'b1) begin
        n_fail++; $display("FAIL midreset_stray%0d: got wb %b ready %b expected 0 1", i, wb_valid, load_ready);
      end
    end
    bus_rvalid = 1'b0;
    run_load(32'h2000, LW, 5'd11, 32'h12345678, 32'h0, lat, data, wrd, nreq, a0, a1);
    n_tests++;
    if (data !== 32'h12345678 || lat !== 3 || a0 !== 32'h2000) begin
      n_fail++; $display("FAIL midreset_next: got data %h lat %0d addr %h expected 12345678 3 00002000", data, lat, a0);
    end
  endtask

  task automatic test_no_misaligned();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load_valid = 1'b1; load_addr = 32'h1003; load_mnemonic = LH; load_rd = 5'd3;
    tick();
    load_valid = 1'b0;
    n_tests++;
    if ({na_load_err, na_bus_req, na_load_ready} !== 3'b101) begin
      n_fail++; $display("FAIL nomis_pulse: got err/req/ready %b expected 101", {na_load_err, na_bus_req, na_load_ready});
    end
    tick();
    n_tests++;
    if ({na_load_err, na_bus_req, na_wb_valid, na_load_ready} !== 4'b0001 ||
        {na_bus_addr, na_wb_rd, na_wb_data} !== '0) begin
      n_fail++; $display("FAIL nomis_after: got flags %b addr %h rd %h data %h expected 0001 and zeros",
                         {na_load_err, na_bus_req, na_wb_valid, na_load_ready}, na_bus_addr, na_wb_rd, na_wb_data);
    end
    n_tests++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h1000 || load_err !== 1'b0) begin
      n_fail++; $display("FAIL mis_accept: got req %b addr %h err %b expected 1 00001000 0", bus_req, bus_addr, load_err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat, nreq;
    logic [31:0] data, a0, a1;
    logic [4:0] wrd;
    run_load(32'h1003, LBU, 5'd30, 32'h9A000000, 32'h0, lat, data, wrd, nreq, a0, a1);
    n_tests++;
    if (data !== 32'h0000009A || lat !== 3) begin
      n_fail++; $display("FAIL b2b_first: got %h lat %0d expected 0000009a 3", data, lat);
    end
    run_load(32'h1001, LH, 5'd31, 32'h00ABCD00, 32'h0, lat, data, wrd, nreq, a0, a1);
    n_tests++;
    if (data !== 32'hFFFFABCD || lat !== 3 || wrd !== 5'd31) begin
      n_fail++; $display("FAIL b2b_second: got %h lat %0d rd %0d expected ffffabcd 3 31", data, lat, wrd);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; load_valid = 1'b0; load_addr = '0; load_mnemonic = LB; load_rd = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rddata = '0;
    test_reset();
    test_aligned();
    test_split();
    test_illegal();
    test_gnt_stall();
    test_reset_mid();
    test_no_misaligned();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_align_unit.md
LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 Parameters: DATA_W, default 32, bus/register width (32 or 64 only); ADDR_W, default 32, byte address width; MISALIGNED_EN, default 1, when 1 word-crossing loads are split into two bus beats, when 0 they are rejected.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 load_valid  in  1  core presents a load.
REQ-006 load_ready  out  1  unit can accept a load.
REQ-007 load_addr  in  ADDR_W  byte address.
REQ-008 load_mnemonic  in  RV32I_INSTRUCTION_MNEMONIC_t  LB, LH, LW, LBU or LHU.
REQ-009 load_rd  in  5  destination register index.
REQ-010 bus_req  out  1  bus read request.
REQ-011 bus_addr  out  ADDR_W  word-aligned read address, low log2(DATA_W/8) bits zero.
REQ-012 bus_gnt  in  1  request accepted this cycle.
REQ-013 bus_rvalid  in  1  read data valid.
REQ-014 bus_rddata  in  DATA_W  read data, little-endian.
REQ-015 wb_valid  out  1  one-cycle writeback pulse.
REQ-016 wb_rd  out  5  writeback register index.
REQ-017 wb_data  out  DATA_W  extended load result.
REQ-018 load_err  out  1  one-cycle pulse on a rejected load.

Function
REQ-019 FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
REQ-020 load_ready is 1 only in IDLE; a load is accepted on load_valid and load_ready, capturing addr, mnemonic and rd.
REQ-021 An accepted load with an illegal mnemonic, or a word-crossing load with MISALIGNED_EN=0, pulses load_err next cycle, stays in IDLE and issues no bus_req.
REQ-022 REQ0 holds bus_req=1 and bus_addr=word(addr) until bus_gnt, then moves to WAIT0.
REQ-023 WAIT0 captures bus_rddata on bus_rvalid, then goes to REQ1 if the access crosses a word boundary, else to DONE.
REQ-024 REQ1 and WAIT1 repeat the request at word(addr)+DATA_W/8 and capture the second beat.
REQ-025 A word-crossing load takes the upper bytes of beat0 followed by the lower bytes of beat1.
REQ-026 Size: LB/LBU 1 byte, LH/LHU 2 bytes, LW 4 bytes.
REQ-027 LB/LH sign-extend to DATA_W; LBU/LHU zero-extend; when DATA_W=64, LW sign-extends.
REQ-028 Field select: bytes starting at byte offset addr mod (DATA_W/8).
REQ-029 DONE asserts wb_valid=1 with wb_rd and wb_data for exactly one cycle, then returns to IDLE.
REQ-030 Minimum aligned latency, with gnt and rvalid both same-cycle: accept T, bus_req T+1, rvalid T+2, wb_valid T+3; split load adds 2 cycles.
REQ-031 bus_rvalid in IDLE, REQ0 or REQ1 is ignored.
REQ-032 bus_addr wraps modulo 2^ADDR_W on the second beat.
REQ-033 wb_data and wb_rd are 0 whenever wb_valid=0.

Reset
REQ-034 rst forces IDLE next edge from any state, including mid-beat.
REQ-035 Reset values: bus_req=0, bus_addr=0, wb_valid=0, wb_rd=0, wb_data=0, load_err=0, load_ready=1 after reset.
REQ-036 Responses arriving after reset are discarded.

Structure
REQ-037 The FSM state enum and the load-size/extension function live in fe_pkg; mnemonics come from RV32I_defines.sv.
REQ-038 One sub-module, load_extend (combinational byte select and extension), is instantiated once.

Verification
REQ-039 LB at 0x1003, rddata 0x80000000 -> wb_data 0xFFFFFF80 at T+3.
REQ-040 LHU at 0x1002, rddata 0xBEEF1234 -> wb_data 0x0000BEEF.
REQ-041 LW at 0x1002, beat0 0x33445566 at 0x1000, beat1 0x778899AA at 0x1004 -> two requests, wb_data 0x99AA3344 at T+5.
REQ-042 MISALIGNED_EN=0, LH at 0x1003 -> load_err pulse, no bus_req, load_ready stays 1.
REQ-043 bus_gnt held low 4 cycles in REQ0 -> bus_req and bus_addr stable throughout; wb after grant+2.
REQ-044 rst asserted in WAIT0, then stray bus_rvalid -> IDLE, no wb_valid, next LW at 0x2000 with rddata 0x12345678 -> wb_data 0x12345678.
